// File: rtl/router_ingress.sv
// router_ingress: 1x3 router ingress FSM that decodes headers and steers packet bytes into per-port FIFOs
module router_ingress (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  output logic [2:0] write_enb,
  output logic [7:0] dout,
  output logic       lfd_state,
  output logic       err,
  output logic       parity_done
);
  localparam logic [2:0] DECODE     = 3'd0;
  localparam logic [2:0] WAIT_EMPTY = 3'd1;
  localparam logic [2:0] LOAD_FIRST = 3'd2;
  localparam logic [2:0] LOAD_DATA  = 3'd3;
  localparam logic [2:0] FULL       = 3'd4;
  localparam logic [2:0] AFTER_FULL = 3'd5;
  localparam logic [2:0] CHECK      = 3'd6;
  localparam logic [2:0] DROP       = 3'd7;
  logic [2:0] state_q, state_d;
  logic [7:0] hdr_q, hdr_d, hold_q, hold_d, calc_q, calc_d, rx_q, rx_d;
  logic [1:0] addr_q, addr_d;
  logic       hold_par_q, hold_par_d, err_q, err_d;
  logic [3:0] empty_x, full_x, soft_x;
  logic       full_a, sr, we;
  // address 3 never reaches a FIFO, so padding with 0 keeps indexing in range
  assign empty_x = {1'b0, fifo_empty};
  assign full_x  = {1'b0, fifo_full};
  assign soft_x  = {1'b0, soft_reset};
  assign full_a  = full_x[addr_q];
  assign sr      = soft_x[addr_q] && state_q != DECODE && state_q != DROP;
  assign we      = !sr && !full_a && (state_q == LOAD_FIRST || state_q == LOAD_DATA || state_q == AFTER_FULL);
  assign write_enb   = we ? 3'b001 << addr_q : 3'b000;
  assign dout        = state_q == LOAD_FIRST ? hdr_q : state_q == AFTER_FULL ? hold_q : state_q == LOAD_DATA ? data_in : 8'd0;
  assign busy        = !(state_q == DECODE || state_q == LOAD_DATA || state_q == DROP);
  assign lfd_state   = state_d == LOAD_FIRST;
  assign parity_done = state_q == CHECK && !sr;
  assign err         = err_q;
  // next-state and datapath updates; soft reset and resetn override last
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    hold_par_d = hold_par_q;
    calc_d     = calc_q;
    rx_d       = rx_q;
    err_d      = err_q;
    case (state_q)
      DECODE: if (pkt_valid) begin
        if (data_in[1:0] == 2'd3) state_d = DROP;
        else begin
          hdr_d   = data_in;
          addr_d  = data_in[1:0];
          calc_d  = data_in;
          err_d   = 1'b0;
          state_d = empty_x[data_in[1:0]] ? LOAD_FIRST : WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: if (empty_x[addr_q]) state_d = LOAD_FIRST;
      LOAD_FIRST: if (!full_a) state_d = LOAD_DATA;
      LOAD_DATA: if (!full_a) begin
        if (pkt_valid) calc_d = calc_q ^ data_in;
        else begin
          rx_d    = data_in;
          state_d = CHECK;
        end
      end else begin
        hold_d     = data_in;
        hold_par_d = !pkt_valid;
        state_d    = FULL;
      end
      FULL: if (!full_a) state_d = AFTER_FULL;
      AFTER_FULL: if (!full_a) begin
        if (hold_par_q) begin
          rx_d    = hold_q;
          state_d = CHECK;
        end else begin
          calc_d  = calc_q ^ hold_q;
          state_d = LOAD_DATA;
        end
      end
      CHECK: begin
        err_d   = calc_q != rx_q;
        state_d = DECODE;
      end
      default: if (!pkt_valid) state_d = DECODE;
    endcase
    if (sr) begin
      state_d = DECODE;
      err_d   = err_q;
    end
    if (!resetn) begin
      state_d    = DECODE;
      hdr_d      = 8'd0;
      addr_d     = 2'd0;
      hold_d     = 8'd0;
      hold_par_d = 1'b0;
      calc_d     = 8'd0;
      rx_d       = 8'd0;
      err_d      = 1'b0;
    end
  end
  // state registers; reset is already folded into the next-state values
  always_ff @(posedge clock) begin
    state_q    <= state_d;
    hdr_q      <= hdr_d;
    addr_q     <= addr_d;
    hold_q     <= hold_d;
    hold_par_q <= hold_par_d;
    calc_q     <= calc_d;
    rx_q       <= rx_d;
    err_q      <= err_d;
  end
endmodule

// File: tb/tb_router_ingress.sv
// tb_router_ingress: directed and random packets checked against a packet-level model of FIFO writes and parity
module tb_router_ingress;
  logic       clock = 0, resetn = 0, pkt_valid = 0;
  logic [7:0] data_in = 0;
  logic [2:0] fifo_full = 0, fifo_empty = 3'b111, soft_reset = 0;
  logic       busy, lfd_state, err, parity_done;
  logic [2:0] write_enb;
  logic [7:0] dout;
  router_ingress dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset), .write_enb(write_enb),
    .dout(dout), .lfd_state(lfd_state), .err(err), .parity_done(parity_done)
  );
  always #5 clock = ~clock;
  int n_assert = 0, n_fail = 0;
  logic [7:0] src[$];
  logic [9:0] wr[$];
  int empty_wait, full_lo, full_hi, sr_at, tail;
  bit rnd_full;
  int lfd_cnt, lfd_cyc, first_wr, last_wr, pd_cnt, busy_cnt, inv_bad;
  logic       busy_log[0:299];
  logic       err_log[0:299];
  logic [2:0] we_log[0:299];
  logic       exp_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  function automatic logic [1:0] port_of(input logic [2:0] w);
    return w == 3'b100 ? 2'd2 : w == 3'b010 ? 2'd1 : 2'd0;
  endfunction
  task automatic knobs(input int ew, input int flo, input int fhi, input bit rf, input int sra);
    empty_wait = ew; full_lo = flo; full_hi = fhi; rnd_full = rf; sr_at = sra;
  endtask
  task automatic add_par(input bit bad);
    logic [7:0] p = 0;
    foreach (src[i]) p ^= src[i];
    src.push_back(bad ? p ^ 8'h5A : p);
  endtask
  task automatic run(input string tag);
    int idx = 0, n = src.size();
    wr.delete();
    lfd_cnt = 0; lfd_cyc = -1; first_wr = -1; last_wr = -1; pd_cnt = 0; busy_cnt = 0; inv_bad = 0; tail = 0;
    for (int c = 0; c < 300 && tail < 3; c++) begin
      @(posedge clock); #1;
      pkt_valid  = idx < n - 1;
      data_in    = idx < n ? src[idx] : 8'd0;
      fifo_empty = c >= empty_wait ? 3'b111 : 3'b000;
      fifo_full  = (c >= full_lo && c < full_hi) || (rnd_full && first_wr >= 0 && $urandom_range(0, 2) == 0) ? 3'b111 : 3'b000;
      soft_reset = c == sr_at ? 3'b111 : 3'b000;
      @(negedge clock);
      busy_log[c] = busy; we_log[c] = write_enb; err_log[c] = err;
      if (write_enb != 0) begin
        wr.push_back({port_of(write_enb), dout});
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if ($countones(write_enb) > 1 || (write_enb & fifo_full) != 0) inv_bad++;
      if (lfd_state) begin
        lfd_cnt++;
        if (lfd_cyc < 0) lfd_cyc = c;
      end
      pd_cnt += int'(parity_done);
      busy_cnt += int'(busy);
      if (c == sr_at) idx = n;
      else if (!busy && idx < n) idx++;
      if (idx == n && !busy) tail++;
    end
    pkt_valid = 0; data_in = 0; fifo_full = 0; soft_reset = 0; fifo_empty = 3'b111;
    chk({tag, "_done"}, tail >= 3, 1);
    chk({tag, "_invariant"}, inv_bad, 0);
  endtask
  task automatic check_pkt(input string tag);
    logic [1:0] port = src[0][1:0];
    logic [7:0] p = 0;
    for (int i = 0; i < src.size() - 1; i++) p ^= src[i];
    if (sr_at >= 0) begin
      chk({tag, "_pd"}, pd_cnt, 0);
      chk({tag, "_err"}, err, exp_err);
      foreach (wr[i]) chk({tag, "_prefix"}, wr[i], {port, src[i]});
    end else if (port == 2'd3) begin
      chk({tag, "_nwr"}, wr.size(), 0);
      chk({tag, "_busy"}, busy_cnt, 0);
      chk({tag, "_pd"}, pd_cnt, 0);
      chk({tag, "_lfd"}, lfd_cnt, 0);
      chk({tag, "_err"}, err, exp_err);
    end else begin
      exp_err = p != src[src.size() - 1];
      chk({tag, "_nwr"}, wr.size(), src.size());
      foreach (wr[i]) if (i < src.size()) chk({tag, "_wr"}, wr[i], {port, src[i]});
      chk({tag, "_pd"}, pd_cnt, 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_lfd_cnt"}, lfd_cnt, 1);
      chk({tag, "_lfd_cyc"}, lfd_cyc, empty_wait);
      chk({tag, "_first_wr"}, first_wr, empty_wait + 1);
    end
  endtask
  initial begin
    exp_err = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_we", write_enb, 0);
    chk("rst_dout", dout, 0);
    chk("rst_lfd", lfd_state, 0);
    chk("rst_err", err, 0);
    chk("rst_pd", parity_done, 0);
    @(posedge clock); #1 resetn = 1;
    src = '{8'h0D, 8'h11, 8'h22, 8'h33};
    add_par(0);
    knobs(0, 0, 0, 0, -1);
    run("p1");
    check_pkt("p1");
    chk("p1_consec", last_wr - first_wr + 1, 5);
    chk("p1_we", we_log[1], 3'b010);
    src = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    run("bad");
    check_pkt("bad");
    chk("bad_err_set", err, 1);
    src = '{8'h08, 8'hA5, 8'h3C};
    add_par(0);
    knobs(4, 0, 0, 0, -1);
    run("wait");
    check_pkt("wait");
    chk("err_before_hdr", err_log[0], 1);
    chk("err_cleared", err_log[1], 0);
    for (int c = 1; c < 4; c++) begin
      chk("wait_busy", busy_log[c], 1);
      chk("wait_we", we_log[c], 0);
    end
    src = '{8'h0E, 8'h71, 8'h82, 8'h93};
    add_par(0);
    knobs(0, 3, 6, 0, -1);
    run("full");
    check_pkt("full");
    chk("full_hold_we", we_log[3], 0);
    chk("full_busy4", busy_log[4], 1);
    chk("full_busy6", busy_log[6], 1);
    chk("full_we6", we_log[6], 0);
    chk("full_after", we_log[7], 3'b100);
    src = '{8'h07, 8'hAA, 8'h55};
    add_par(0);
    knobs(0, 0, 0, 0, -1);
    run("drop");
    check_pkt("drop");
    src = '{8'h0C, 8'h01, 8'h02, 8'h03};
    add_par(0);
    knobs(0, 0, 0, 0, 3);
    run("sr");
    check_pkt("sr");
    chk("sr_nwr", wr.size(), 2);
    chk("sr_we", we_log[3], 0);
    chk("sr_decode_busy", busy_log[4], 0);
    chk("sr_decode_we", we_log[4], 0);
    src = '{8'h05, 8'hC3};
    add_par(0);
    knobs(0, 0, 0, 0, -1);
    run("after_sr");
    check_pkt("after_sr");
    for (int k = 0; k < 20; k++) begin
      int len = $urandom_range(1, 8);
      src = '{{6'(len), 2'($urandom_range(0, 3))}};
      for (int i = 0; i < len; i++) src.push_back(8'($urandom));
      add_par($urandom_range(0, 2) == 0);
      knobs($urandom_range(0, 3), 0, 0, 1, -1);
      run($sformatf("rnd%0d", k));
      check_pkt($sformatf("rnd%0d", k));
    end
    src = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    knobs(0, 0, 0, 0, -1);
    run("pre_rst");
    check_pkt("pre_rst");
    @(posedge clock); #1 pkt_valid = 1; data_in = 8'h09;
    @(posedge clock); #1 pkt_valid = 0; resetn = 0;
    @(negedge clock);
    chk("mid_rst_lfd", lfd_state, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", write_enb, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_pd", parity_done, 0);
    @(posedge clock); #1 resetn = 1;
    exp_err = 0;
    src = '{8'h06, 8'h44};
    add_par(0);
    run("post_rst");
    check_pkt("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
